// File: rtl/sensor_pkg.sv
// sensor_pkg: shared request-state encoding and default timing for the sensor conditioner.
package sensor_pkg;
  localparam int DEB_CYCLES_DEF = 16;
  localparam int STUCK_CYCLES_DEF = 1024;
  typedef enum logic [1:0] {IDLE, PEND, SERVED} req_state_t;
endpackage

// File: rtl/sensor_channel.sv
// sensor_channel: synchronizes, debounces and latches one car-detector loop into a served/unserved request.
module sensor_channel
  import sensor_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic green,
  output logic req,
  output logic fault
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  logic [1:0] sync;
  logic deb, deb_d, rise;
  logic [DW-1:0] dcnt;
  logic [SW-1:0] scnt;
  req_state_t state, nxt;
  assign rise = deb & ~deb_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      deb <= 1'b0;
      deb_d <= 1'b0;
      dcnt <= '0;
      scnt <= '0;
      fault <= 1'b0;
      state <= IDLE;
    end else begin
      sync <= {sync[0], raw};
      deb_d <= deb;
      if (sync[1] == deb) dcnt <= '0;
      else if (dcnt == DW'(DEB_CYCLES - 1)) begin
        dcnt <= '0;
        deb <= ~deb;
      end else dcnt <= dcnt + 1'b1;
      scnt <= !deb ? '0 : (scnt == SW'(STUCK_CYCLES) ? scnt : scnt + 1'b1);
      fault <= deb && scnt == SW'(STUCK_CYCLES);
      state <= nxt;
    end
  // a request stays latched in PEND until the street actually gets green
  always_comb
    nxt = state == IDLE   ? (rise ? (green ? SERVED : PEND) : IDLE) :
          state == PEND   ? (green ? SERVED : PEND) :
          state == SERVED ? (green ? SERVED : (deb ? PEND : IDLE)) : IDLE;
  assign req = fault | (state == PEND);
endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: two independent detector channels feeding the signal controller's Sa/Sb inputs.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  input  logic Vea,
  input  logic Veb,
  output logic Sa,
  output logic Sb,
  output logic fault_a,
  output logic fault_b
);
  sensor_channel #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_a (
    .clk(clk), .reset(reset), .raw(raw_a), .green(Vea), .req(Sa), .fault(fault_a)
  );
  sensor_channel #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_b (
    .clk(clk), .reset(reset), .raw(raw_b), .green(Veb), .req(Sb), .fault(fault_b)
  );
endmodule
